sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single user port of the SDRAM controller between two requesters (r0 = SDRAM test engine, r1 = secondary client).
//  Each requester sees the same handshake the controller offers: busy / command-received / data-available.
//  Round-robin grant, one transaction in flight at a time; read data is routed back only to the granted requester.
//  Sits between the requester modules and the SDRAM controller user interface, in the inputClock domain.
// PARAMETERS
//  ADDR_W          25        SDRAM word address width
//  DATA_W          16        SDRAM data width
//  MIN_WAIT        1         cycles after accept during which ctrl_is_busy is ignored (1..15)
//  TIMEOUT_CYCLES  1024      ISSUE-state watchdog limit (used only with SDRAM_ARB_TIMEOUT_EN)
// PORTS
//  inputClock            in   1          system clock (143 MHz)
//  reset                 in   1          synchronous, active-high reset
//  req_valid             in   2          bit i: requester i presents a command
//  req_write             in   2          bit i: 1 = write, 0 = read
//  req_addr              in   2*ADDR_W   [i*ADDR_W +: ADDR_W] = address of requester i
//  req_wdata             in   2*DATA_W   [i*DATA_W +: DATA_W] = write data of requester i
//  req_busy              out  2          bit i: port unavailable to requester i
//  req_accepted          out  2          bit i: 1-cycle pulse, command of requester i taken by controller
//  rd_valid              out  2          bit i: 1-cycle pulse, rd_data valid for requester i
//  rd_data               out  DATA_W     read data (shared bus, qualified by rd_valid)
//  ctrl_is_busy          in   1          controller busy
//  ctrl_recieved_command in   1          controller accepted the presented command
//  ctrl_data_available   in   1          controller read data valid
//  ctrl_read_data        in   DATA_W     controller read data
//  ctrl_valid            out  1          command valid to controller
//  ctrl_is_writing       out  1          1 = write command
//  ctrl_address          out  ADDR_W     command address
//  ctrl_data             out  DATA_W     write data
//  arb_timeout           out  1          sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, last_grant=1 (r0 wins the first tie), grant=0, counters 0. Reset mid-transaction
//   abandons it: ctrl_valid low after the reset edge; no req_accepted or rd_valid pulse issued.
//  req_busy[i] (combinational) = (state!=IDLE) | ctrl_is_busy; both bits are identical.
//  IDLE: ctrl_valid=0. If !ctrl_is_busy and any req_valid: grant = the sole valid requester; if both valid,
//   grant = ~last_grant. Latch req_write/addr/wdata of the winner into ctrl_* regs; go to ISSUE.
//   Latency: req_valid at edge N -> ctrl_valid=1 after edge N+1.
//  ISSUE: ctrl_valid=1, ctrl_* stable. On ctrl_recieved_command=1: ctrl_valid<=0, req_accepted[grant]<=1 for one
//   cycle, wait_cnt<=MIN_WAIT, go to WAIT. req_valid changes during ISSUE are ignored (latched copy is used).
//  WAIT: ctrl_valid=0. wait_cnt decrements to 0. Exit to IDLE when wait_cnt==0 and !ctrl_is_busy; on exit
//   last_grant<=grant. req_valid during WAIT is ignored.
//  Read return: ctrl_data_available=1 at edge K, in WAIT or ISSUE -> rd_valid[grant]=1 and rd_data=ctrl_read_data
//   after edge K+1, for one cycle. Data arriving in IDLE is dropped. Data arriving in the same cycle busy drops is
//   still forwarded (rd_valid pulse coincides with the return to IDLE).
//  Writes produce no rd_valid. Only one bit of req_accepted / rd_valid is ever high.
//  Fairness: with both requesters continuously valid, grants strictly alternate r0,r1,r0,...
// CONFIGURATION
//  SDRAM_ARB_TIMEOUT_EN defined: a 16-bit counter runs in ISSUE; when it reaches TIMEOUT_CYCLES with no
//   ctrl_recieved_command: ctrl_valid<=0, arb_timeout<=1 (sticky until reset), last_grant<=grant, no req_accepted,
//   go to IDLE. Counter clears on entry to ISSUE.
//  Not defined: no counter; ISSUE waits indefinitely; arb_timeout is tied to 0.
// TESTING
//  1 r0 write addr=0x0000123 data=0xBEEF, ctrl accepts 3 cycles later -> ctrl_valid 3 cycles, req_accepted=2'b01 one
//    cycle, no rd_valid, IDLE once busy drops.
//  2 r1 read addr=0x1FFFFFF, ctrl returns 0xA5A5 -> rd_valid=2'b10 one cycle with rd_data=0xA5A5; r0 sees no rd_valid.
//  3 both valid every cycle for 6 transactions after reset -> grant order r0,r1,r0,r1,r0,r1; ctrl_address tracks the winner.
//  4 ctrl_is_busy=1 while r0 valid -> ctrl_valid stays 0, req_busy=2'b11; busy drops -> ctrl_valid next cycle.
//  5 reset pulsed in ISSUE and again in WAIT -> ctrl_valid=0, req_accepted=0, rd_valid=0, next grant goes to r0.
//  6 SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ctrl never accepts -> ctrl_valid drops after 8 cycles, arb_timeout=1
//    sticky, pending r1 is granted next; without the macro ctrl_valid stays high and arb_timeout=0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the two requesters, the SDRAM port arbiter and the controller user port.
// master = arbiter view, slave = the surrounding requesters/controller.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    // Handshake: a requester holds req_valid[i] with stable write/addr/wdata until req_accepted[i] pulses;
    // req_busy only advertises whether a new command could be taken. Toward the controller, ctrl_valid
    // with stable ctrl_* is held until ctrl_recieved_command; read data is qualified only by rd_valid.
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_busy;
    logic [1:0]          req_accepted;
    logic [1:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                ctrl_is_busy;
    logic                ctrl_recieved_command;
    logic                ctrl_data_available;
    logic [DATA_W-1:0]   ctrl_read_data;
    logic                ctrl_valid;
    logic                ctrl_is_writing;
    logic [ADDR_W-1:0]   ctrl_address;
    logic [DATA_W-1:0]   ctrl_data;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  ctrl_is_busy, ctrl_recieved_command, ctrl_data_available, ctrl_read_data,
        output req_busy, req_accepted, rd_valid, rd_data,
        output ctrl_valid, ctrl_is_writing, ctrl_address, ctrl_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output ctrl_is_busy, ctrl_recieved_command, ctrl_data_available, ctrl_read_data,
        input  req_busy, req_accepted, rd_valid, rd_data,
        input  ctrl_valid, ctrl_is_writing, ctrl_address, ctrl_data
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of the SDRAM controller user port between two requesters, one command in flight.
// Optional ISSUE watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int MIN_WAIT       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 inputClock,
    input  logic                 reset,
    sdram_port_arbiter_if.master bus,
    output logic                 arb_timeout,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MIN_WAIT);

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [3:0]        r_wait_cnt;
    logic              r_ctrl_valid;
    logic              r_ctrl_is_writing;
    logic [ADDR_W-1:0] r_ctrl_address;
    logic [DATA_W-1:0] r_ctrl_data;
    logic [1:0]        r_req_accepted;
    logic [1:0]        r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_arb_timeout;
    logic              w_pick;
    logic              w_start;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_to_cnt;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // A tie goes to whoever did not win last time.
    always_comb begin
        w_pick = 1'b0;
        if (bus.req_valid == 2'b10) begin
            w_pick = 1'b1;
        end else if (bus.req_valid == 2'b11) begin
            w_pick = ~r_last_grant;
        end
    end

    assign w_start = (bus.req_valid != 2'b00) && !bus.ctrl_is_busy;

    always_ff @(posedge inputClock) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_grant           <= 1'b0;
            r_last_grant      <= 1'b1;
            r_wait_cnt        <= '0;
            r_ctrl_valid      <= 1'b0;
            r_ctrl_is_writing <= 1'b0;
            r_ctrl_address    <= '0;
            r_ctrl_data       <= '0;
            r_req_accepted    <= '0;
            r_rd_valid        <= '0;
            r_rd_data         <= '0;
            r_arb_timeout     <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_to_cnt          <= '0;
`endif
        end else begin
            r_req_accepted <= '0;
            r_rd_valid     <= '0;

            // Read data is routed to the owner of the transaction; anything arriving while idle is dropped.
            if (bus.ctrl_data_available && (r_state != ST_IDLE)) begin
                r_rd_valid[r_grant] <= 1'b1;
                r_rd_data           <= bus.ctrl_read_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_grant           <= w_pick;
                        r_ctrl_is_writing <= bus.req_write[w_pick];
                        r_ctrl_address    <= w_pick ? bus.req_addr[ADDR_W +: ADDR_W]
                                                    : bus.req_addr[0 +: ADDR_W];
                        r_ctrl_data       <= w_pick ? bus.req_wdata[DATA_W +: DATA_W]
                                                    : bus.req_wdata[0 +: DATA_W];
                        r_ctrl_valid      <= 1'b1;
                        r_state           <= ST_ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                        r_to_cnt          <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (bus.ctrl_recieved_command) begin
                        r_ctrl_valid            <= 1'b0;
                        r_req_accepted[r_grant] <= 1'b1;
                        r_wait_cnt              <= WAIT_INIT;
                        r_state                 <= ST_WAIT;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_ctrl_valid  <= 1'b0;
                        r_arb_timeout <= 1'b1;
                        r_last_grant  <= r_grant;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end

                // The controller may not raise busy immediately after accepting, so busy is ignored for MIN_WAIT cycles.
                ST_WAIT: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else if (!bus.ctrl_is_busy) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_busy        = {2{(r_state != ST_IDLE) | bus.ctrl_is_busy}};
    assign bus.req_accepted    = r_req_accepted;
    assign bus.rd_valid        = r_rd_valid;
    assign bus.rd_data         = r_rd_data;
    assign bus.ctrl_valid      = r_ctrl_valid;
    assign bus.ctrl_is_writing = r_ctrl_is_writing;
    assign bus.ctrl_address    = r_ctrl_address;
    assign bus.ctrl_data       = r_ctrl_data;
    assign arb_timeout         = r_arb_timeout;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios followed by randomized transactions against a
// transaction-level model of grant order, command contents, accept/exit timing and read routing.
module tb_sdram_port_arbiter;
    localparam int AW       = 25;
    localparam int DW       = 16;
    localparam int AW2      = 2 * AW;
    localparam int MIN_WAIT = 1;
    localparam int TO_CYC   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       arb_timeout;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic          model_last;
    logic          model_to;
    logic [DW-1:0] exp_q[$];

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .inputClock (clk),
        .reset      (rst),
        .bus        (bus),
        .arb_timeout(arb_timeout),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level winner: sole requester wins, a tie goes to the one not served last.
    function automatic int winner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return model_last ? 0 : 1;
    endfunction

    task automatic clear_inputs();
        bus.req_valid             = '0;
        bus.req_write             = '0;
        bus.req_addr              = '0;
        bus.req_wdata             = '0;
        bus.ctrl_is_busy          = 1'b0;
        bus.ctrl_recieved_command = 1'b0;
        bus.ctrl_data_available   = 1'b0;
        bus.ctrl_read_data        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        model_last = 1'b1;
        model_to   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_rd(input bit expect_rd, input logic [1:0] onehot);
        logic [DW-1:0] e;
        if (expect_rd) begin
            chk("rd_valid", bus.rd_valid, onehot);
            e = exp_q.pop_front();
            chk("rd_data", bus.rd_data, e);
        end else begin
            chk("rd_quiet", bus.rd_valid, 2'b00);
        end
    endtask

    // Runs one complete transaction from IDLE back to IDLE, checking every cycle.
    task automatic run_txn(input logic [1:0] v, input logic [1:0] wr,
                           input logic [AW2-1:0] addr, input logic [2*DW-1:0] wd,
                           input int pre_busy, input int acc_dly, input int busy_cyc,
                           input int ret_sel, input logic [DW-1:0] rdat, input bit scramble,
                           output int got_w);
        int            w;
        int            k_exit;
        int            ret_at;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        logic [1:0]    onehot;
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        for (int p = 0; p < pre_busy; p++) begin
            bus.ctrl_is_busy = 1'b1;
            tick();
            chk("hold_cv", bus.ctrl_valid, 1'b0);
            chk("hold_busy", bus.req_busy, 2'b11);
        end
        bus.ctrl_is_busy = 1'b0;
        w      = winner(v);
        ea     = addr[w*AW +: AW];
        ed     = wd[w*DW +: DW];
        ew     = wr[w];
        onehot = 2'b01 << w;
        tick();
        chk("issue_cv", bus.ctrl_valid, 1'b1);
        chk("issue_addr", bus.ctrl_address, ea);
        chk("issue_data", bus.ctrl_data, ed);
        chk("issue_wr", bus.ctrl_is_writing, ew);
        chk("issue_busy", bus.req_busy, 2'b11);
        chk("issue_acc", bus.req_accepted, 2'b00);
        for (int d = 0; d < acc_dly; d++) begin
            if (scramble) begin
                bus.req_valid = 2'($urandom_range(0, 3));
                bus.req_write = 2'($urandom_range(0, 3));
                bus.req_addr  = AW2'({$urandom(), $urandom()});
                bus.req_wdata = $urandom();
            end
            tick();
            chk("stable_cv", bus.ctrl_valid, 1'b1);
            chk("stable_addr", bus.ctrl_address, ea);
            chk("stable_data", bus.ctrl_data, ed);
            chk("stable_wr", bus.ctrl_is_writing, ew);
            chk("stable_acc", bus.req_accepted, 2'b00);
            chk("stable_rd", bus.rd_valid, 2'b00);
        end
        bus.ctrl_recieved_command = 1'b1;
        bus.ctrl_is_busy          = (busy_cyc > 0);
        k_exit = (busy_cyc > MIN_WAIT) ? busy_cyc + 1 : MIN_WAIT + 1;
        ret_at = ew ? -1 : ret_sel % (k_exit + 1);
        if (ret_at == 0) begin
            bus.ctrl_data_available = 1'b1;
            bus.ctrl_read_data      = rdat;
            exp_q.push_back(rdat);
        end
        tick();
        chk("acc", bus.req_accepted, onehot);
        got_w = bus.req_accepted[1] ? 1 : 0;
        chk("acc_cv", bus.ctrl_valid, 1'b0);
        chk("acc_to", arb_timeout, model_to);
        check_rd(ret_at == 0, onehot);
        bus.ctrl_recieved_command = 1'b0;
        bus.ctrl_data_available   = 1'b0;
        for (int k = 1; k <= k_exit; k++) begin
            bus.ctrl_is_busy = (k <= busy_cyc);
            if (k == ret_at) begin
                bus.ctrl_data_available = 1'b1;
                bus.ctrl_read_data      = rdat;
                exp_q.push_back(rdat);
            end
            if (scramble) bus.req_valid = 2'($urandom_range(0, 3));
            tick();
            chk("wait_busy", bus.req_busy, (k < k_exit) ? 2'b11 : 2'b00);
            chk("wait_cv", bus.ctrl_valid, 1'b0);
            chk("wait_acc", bus.req_accepted, 2'b00);
            check_rd(k == ret_at, onehot);
            bus.ctrl_data_available = 1'b0;
        end
        model_last    = w[0];
        bus.req_valid = 2'b00;
    endtask

    initial begin
        int            got;
        logic [1:0]    v;
        logic [DW-1:0] rd;
        rst = 1'b1;
        clear_inputs();
        model_last = 1'b1;
        model_to   = 1'b0;
        tick();
        tick();
        chk("rst_cv", bus.ctrl_valid, 1'b0);
        chk("rst_acc", bus.req_accepted, 2'b00);
        chk("rst_rdv", bus.rd_valid, 2'b00);
        chk("rst_rdd", bus.rd_data, 16'h0);
        chk("rst_addr", bus.ctrl_address, 25'h0);
        chk("rst_data", bus.ctrl_data, 16'h0);
        chk("rst_wr", bus.ctrl_is_writing, 1'b0);
        chk("rst_busy", bus.req_busy, 2'b00);
        chk("rst_to", arb_timeout, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_cv", bus.ctrl_valid, 1'b0);

        // r0 write, accepted after three cycles of ctrl_valid
        run_txn(2'b01, 2'b01, {25'h0, 25'h0000123}, {16'h0, 16'hBEEF}, 0, 2, 2, 0, 16'h0, 1'b0, got);
        chk("t1_grant", got, 0);

        // r1 read of the top address, data routed to r1 only
        run_txn(2'b10, 2'b00, {25'h1FFFFFF, 25'h0000001}, {16'h1111, 16'h2222}, 0, 1, 3, 2, 16'hA5A5, 1'b0, got);
        chk("t2_grant", got, 1);

        // data arriving while idle is dropped
        bus.ctrl_data_available = 1'b1;
        bus.ctrl_read_data      = 16'h5A5A;
        tick();
        chk("idle_drop", bus.rd_valid, 2'b00);
        bus.ctrl_data_available = 1'b0;
        tick();
        chk("idle_drop2", bus.rd_valid, 2'b00);

        // both requesters continuously valid: strict alternation from r0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_txn(2'b11, 2'($urandom_range(0, 3)), AW2'({$urandom(), $urandom()}), $urandom(),
                    0, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 5),
                    DW'($urandom()), 1'b0, got);
            chk("fair_order", got, i % 2);
        end

        // controller busy holds off the grant
        run_txn(2'b01, 2'b00, {25'h0, 25'h0ABCDEF}, {16'h0, 16'h0}, 3, 0, 0, 1, 16'h3C3C, 1'b0, got);
        chk("t4_grant", got, 0);

        // reset during ISSUE, then during WAIT
        do_reset();
        bus.req_valid = 2'b10;
        bus.req_addr  = {25'h0AAAAAA, 25'h0155555};
        bus.req_wdata = {16'h1234, 16'h5678};
        tick();
        chk("r5_issue_r1", bus.ctrl_address, 25'h0AAAAAA);
        rst = 1'b1;
        bus.req_valid             = 2'b00;
        bus.ctrl_recieved_command = 1'b1;
        bus.ctrl_data_available   = 1'b1;
        bus.ctrl_read_data        = 16'hDEAD;
        tick();
        chk("r5a_cv", bus.ctrl_valid, 1'b0);
        chk("r5a_acc", bus.req_accepted, 2'b00);
        chk("r5a_rdv", bus.rd_valid, 2'b00);
        rst = 1'b0;
        bus.ctrl_recieved_command = 1'b0;
        bus.ctrl_data_available   = 1'b0;
        model_last = 1'b1;
        tick();
        chk("r5a_after_acc", bus.req_accepted, 2'b00);
        chk("r5a_after_rdv", bus.rd_valid, 2'b00);
        bus.req_valid = 2'b11;
        tick();
        chk("r5_issue_r0", bus.ctrl_address, 25'h0155555);
        bus.req_valid             = 2'b00;
        bus.ctrl_recieved_command = 1'b1;
        bus.ctrl_is_busy          = 1'b1;
        tick();
        chk("r5_acc", bus.req_accepted, 2'b01);
        bus.ctrl_recieved_command = 1'b0;
        rst = 1'b1;
        bus.ctrl_data_available = 1'b1;
        tick();
        chk("r5b_cv", bus.ctrl_valid, 1'b0);
        chk("r5b_acc", bus.req_accepted, 2'b00);
        chk("r5b_rdv", bus.rd_valid, 2'b00);
        rst = 1'b0;
        bus.ctrl_data_available = 1'b0;
        bus.ctrl_is_busy        = 1'b0;
        model_last = 1'b1;
        tick();
        chk("r5b_idle", bus.req_busy, 2'b00);
        chk("r5b_rdv2", bus.rd_valid, 2'b00);
        run_txn(2'b11, 2'b00, {25'h0000222, 25'h0000111}, {16'h0, 16'h0}, 0, 1, 1, 1, 16'h7E7E, 1'b0, got);
        chk("r5_next_r0", got, 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // controller never accepts: watchdog drops the command and r1 is served next
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_addr  = {25'h1000002, 25'h1000001};
        tick();
        chk("to_cv_start", bus.ctrl_valid, 1'b1);
        chk("to_addr", bus.ctrl_address, 25'h1000001);
        for (int i = 1; i < TO_CYC; i++) begin
            tick();
            chk("to_cv_hold", bus.ctrl_valid, 1'b1);
            chk("to_flag_low", arb_timeout, 1'b0);
        end
        tick();
        chk("to_cv_drop", bus.ctrl_valid, 1'b0);
        chk("to_flag", arb_timeout, 1'b1);
        chk("to_no_acc", bus.req_accepted, 2'b00);
        model_last = 1'b0;
        model_to   = 1'b1;
        run_txn(2'b11, 2'b00, {25'h1000002, 25'h1000001}, {16'h0, 16'h0}, 0, 0, 0, 0, 16'h0F0F, 1'b0, got);
        chk("to_next_r1", got, 1);
        tick();
        chk("to_sticky", arb_timeout, 1'b1);
`else
        // without the watchdog the command is held indefinitely
        do_reset();
        bus.req_valid = 2'b01;
        tick();
        chk("nto_cv_start", bus.ctrl_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nto_cv_hold", bus.ctrl_valid, 1'b1);
            chk("nto_flag", arb_timeout, 1'b0);
            chk("nto_acc", bus.req_accepted, 2'b00);
        end
`endif
        do_reset();

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            v  = 2'($urandom_range(1, 3));
            rd = DW'($urandom());
            run_txn(v, 2'($urandom_range(0, 3)), AW2'({$urandom(), $urandom()}), $urandom(),
                    $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 6), rd, 1'b1, got);
            if ((i % 6) == 5) begin
                bus.ctrl_data_available = 1'b1;
                bus.ctrl_read_data      = rd;
                tick();
                chk("rand_idle_drop", bus.rd_valid, 2'b00);
                bus.ctrl_data_available = 1'b0;
            end
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
